// File: rtl/gcd_driver_if.sv
// Bundle of the upstream operand port, downstream result port and the
// two-cycle GCD operand interface driven by gcd_driver.
interface gcd_driver_if #(
    parameter int W  = 16,
    parameter int CW = 17
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_gcd;
    logic [CW-1:0] out_cycles;
    logic          out_err;
    logic          gcd_irdy;
    logic [W-1:0]  gcd_din;
    logic          gcd_ordy;
    logic [W-1:0]  gcd_dout;

    // Driver side
    modport master (
        input  in_valid, in_a, in_b, out_ready, gcd_ordy, gcd_dout,
        output in_ready, out_valid, out_gcd, out_cycles, out_err, gcd_irdy, gcd_din
    );

    // Environment side (producer, consumer and GCD core)
    modport slave (
        output in_valid, in_a, in_b, out_ready, gcd_ordy, gcd_dout,
        input  in_ready, out_valid, out_gcd, out_cycles, out_err, gcd_irdy, gcd_din
    );
endinterface

// File: rtl/gcd_driver.sv
// Initiator for a two-cycle GCD operand interface: takes an operand pair,
// sends A then B, waits for the result with a timeout, and holds the result
// together with its WAIT-cycle count until the consumer accepts it.
module gcd_driver #(
    parameter int W       = 16,
    parameter int TIMEOUT = 131071,
    parameter int CW      = 17
) (
    input  logic         clk,
    input  logic         reset,
    gcd_driver_if.master bus
);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_A = 3'd1,
        S_SEND_B = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [W-1:0]  r_out_gcd;
    logic [CW-1:0] r_out_cycles;
    logic          r_out_err;
    logic          r_gcd_irdy;
    logic [W-1:0]  r_gcd_din;

    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic [W-1:0]  w_out_gcd;
    logic [CW-1:0] w_out_cycles;
    logic          w_out_err;
    logic [W-1:0]  w_gcd_din;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_gcd_irdy;

    assign w_cnt_inc = r_cnt + {{(CW-1){1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and next values for every registered output.
    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
        w_next_state = r_state;
        w_a          = r_a;
        w_b          = r_b;
        w_cnt        = r_cnt;
        w_out_gcd    = r_out_gcd;
        w_out_cycles = r_out_cycles;
        w_out_err    = r_out_err;
        w_gcd_din    = r_gcd_din;
        case (r_state)
            S_IDLE: begin
                // gcd_ordy is meaningless here (X after GCD reset)
                if (bus.in_valid && r_in_ready) begin
                    w_a          = bus.in_a;
                    w_b          = bus.in_b;
                    w_gcd_din    = bus.in_a;
                    w_next_state = S_SEND_A;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SEND_A: begin
                w_gcd_din    = r_b;
                w_next_state = S_SEND_B;
            end
            S_SEND_B: begin
                w_cnt        = {CW{1'b0}};
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // count includes the current WAIT cycle, so it is >= 1
                w_cnt = w_cnt_inc;
                if (bus.gcd_ordy) begin
                    w_out_gcd    = bus.gcd_dout;
                    w_out_cycles = w_cnt_inc;
                    w_out_err    = 1'b0;
                    w_next_state = S_HOLD;
                end else if (r_cnt == TO_LAST) begin
                    w_out_gcd    = {W{1'b0}};
                    w_out_cycles = TO_VAL;
                    w_out_err    = 1'b1;
                    w_next_state = S_HOLD;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_next_state = r_out_err ? S_DRAIN : S_IDLE;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            S_DRAIN: begin
                // GCD still busy after a timeout; never issue irdy into it
                if (bus.gcd_ordy) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        w_in_ready  = (w_next_state == S_IDLE);
        w_out_valid = (w_next_state == S_HOLD);
        w_gcd_irdy  = (w_next_state == S_SEND_A);
    end

    // Operand, counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a          <= {W{1'b0}};
            r_b          <= {W{1'b0}};
            r_cnt        <= {CW{1'b0}};
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_gcd    <= {W{1'b0}};
            r_out_cycles <= {CW{1'b0}};
            r_out_err    <= 1'b0;
            r_gcd_irdy   <= 1'b0;
            r_gcd_din    <= {W{1'b0}};
        end else begin
            r_a          <= w_a;
            r_b          <= w_b;
            r_cnt        <= w_cnt;
            r_in_ready   <= w_in_ready;
            r_out_valid  <= w_out_valid;
            r_out_gcd    <= w_out_gcd;
            r_out_cycles <= w_out_cycles;
            r_out_err    <= w_out_err;
            r_gcd_irdy   <= w_gcd_irdy;
            r_gcd_din    <= w_gcd_din;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_gcd    = r_out_gcd;
    assign bus.out_cycles = r_out_cycles;
    assign bus.out_err    = r_out_err;
    assign bus.gcd_irdy   = r_gcd_irdy;
    assign bus.gcd_din    = r_gcd_din;
endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver: two instances (default timeout and TIMEOUT=100),
// each attached to a subtractive GCD core model, checked against Euclid
// and a step count computed directly from the operands.
module tb_gcd_driver;
    localparam int W      = 16;
    localparam int CW     = 17;
    localparam int TO0    = 131071;
    localparam int TO1    = 100;

    logic clk;
    logic reset;

    logic [1:0]    tb_in_valid;
    logic [W-1:0]  tb_in_a [2];
    logic [W-1:0]  tb_in_b [2];
    logic [1:0]    tb_out_ready;

    logic [1:0]    o_in_ready;
    logic [1:0]    o_out_valid;
    logic [W-1:0]  o_gcd [2];
    logic [CW-1:0] o_cycles [2];
    logic [1:0]    o_err;
    logic [1:0]    o_irdy;
    logic [W-1:0]  o_din [2];

    // GCD core models
    logic [W-1:0]  g_a [2];
    logic [W-1:0]  g_b [2];
    logic [1:0]    g_ordy;
    logic [1:0]    g_busy;
    logic [1:0]    g_loadb;

    int n_irdy0;
    int n_irdy1;
    int n_checks;
    int n_errors;

    gcd_driver_if #(.W(W), .CW(CW)) if0 ();
    gcd_driver_if #(.W(W), .CW(CW)) if1 ();

    gcd_driver #(.W(W), .TIMEOUT(TO0), .CW(CW)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.master));
    gcd_driver #(.W(W), .TIMEOUT(TO1), .CW(CW)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.master));

    assign if0.in_valid  = tb_in_valid[0];
    assign if0.in_a      = tb_in_a[0];
    assign if0.in_b      = tb_in_b[0];
    assign if0.out_ready = tb_out_ready[0];
    assign if0.gcd_ordy  = g_ordy[0];
    assign if0.gcd_dout  = g_a[0];
    assign if1.in_valid  = tb_in_valid[1];
    assign if1.in_a      = tb_in_a[1];
    assign if1.in_b      = tb_in_b[1];
    assign if1.out_ready = tb_out_ready[1];
    assign if1.gcd_ordy  = g_ordy[1];
    assign if1.gcd_dout  = g_a[1];

    assign o_in_ready[0]  = if0.in_ready;
    assign o_out_valid[0] = if0.out_valid;
    assign o_gcd[0]       = if0.out_gcd;
    assign o_cycles[0]    = if0.out_cycles;
    assign o_err[0]       = if0.out_err;
    assign o_irdy[0]      = if0.gcd_irdy;
    assign o_din[0]       = if0.gcd_din;
    assign o_in_ready[1]  = if1.in_ready;
    assign o_out_valid[1] = if1.out_valid;
    assign o_gcd[1]       = if1.out_gcd;
    assign o_cycles[1]    = if1.out_cycles;
    assign o_err[1]       = if1.out_err;
    assign o_irdy[1]      = if1.gcd_irdy;
    assign o_din[1]       = if1.gcd_din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subtractive GCD core: A on irdy, B next cycle, one step per cycle,
    // ordy registered and raised as soon as B becomes zero.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                g_a[k]     <= '0;
                g_b[k]     <= '0;
                g_ordy[k]  <= 1'b1;
                g_busy[k]  <= 1'b0;
                g_loadb[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (o_irdy[k]) begin
                    g_a[k]     <= o_din[k];
                    g_ordy[k]  <= 1'b0;
                    g_loadb[k] <= 1'b1;
                    g_busy[k]  <= 1'b1;
                end else if (g_loadb[k]) begin
                    g_b[k]     <= o_din[k];
                    g_loadb[k] <= 1'b0;
                    g_ordy[k]  <= (o_din[k] == '0);
                    g_busy[k]  <= (o_din[k] != '0);
                end else if (g_busy[k]) begin
                    if (g_a[k] < g_b[k]) begin
                        g_a[k] <= g_b[k];
                        g_b[k] <= g_a[k];
                        if (g_a[k] == '0) begin
                            g_ordy[k] <= 1'b1;
                            g_busy[k] <= 1'b0;
                        end
                    end else begin
                        g_a[k] <= g_a[k] - g_b[k];
                    end
                end
            end
        end
    end

    // irdy pulse counters
    always @(posedge clk) begin
        if (o_irdy[0]) n_irdy0 <= n_irdy0 + 1;
        if (o_irdy[1]) n_irdy1 <= n_irdy1 + 1;
    end

    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // WAIT cycles until ordy is seen: one per subtract/swap step, plus one
    function automatic int ref_cycles(input int a, input int b);
        int x = a;
        int y = b;
        int n = 0;
        int t;
        while (y != 0) begin
            n++;
            if (x < y) begin
                t = x; x = y; y = t;
            end else begin
                x = x - y;
            end
        end
        return n + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int irdy_count(input int k);
        return (k == 0) ? n_irdy0 : n_irdy1;
    endfunction

    task automatic check_reset_state(input int k);
        check("rst_in_ready", {31'd0, o_in_ready[k]}, 32'd1);
        check("rst_out_valid", {31'd0, o_out_valid[k]}, 32'd0);
        check("rst_out_gcd", {16'd0, o_gcd[k]}, 32'd0);
        check("rst_out_cycles", {15'd0, o_cycles[k]}, 32'd0);
        check("rst_out_err", {31'd0, o_err[k]}, 32'd0);
        check("rst_irdy", {31'd0, o_irdy[k]}, 32'd0);
        check("rst_din", {16'd0, o_din[k]}, 32'd0);
    endtask

    // One full operation; starts and ends at a negedge.
    task automatic run_op(input int k, input int a, input int b, input int hold,
                          input bit stream, input int to);
        int  cyc      = ref_cycles(a, b);
        bit  exp_err  = (cyc > to);
        int  exp_cyc  = exp_err ? to : cyc;
        int  exp_gcd  = exp_err ? 0 : ref_gcd(a, b);
        int  lat;
        int  irdy0;
        bit  ok;
        bit  prev_ordy;
        tb_in_a[k]     = W'(a);
        tb_in_b[k]     = W'(b);
        tb_in_valid[k] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (o_in_ready[k]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("accept_wait", {31'd0, ok}, 32'd1);
        irdy0 = irdy_count(k);
        @(posedge clk);
        @(negedge clk);
        if (!stream) tb_in_valid[k] = 1'b0;
        check("send_a_irdy", {31'd0, o_irdy[k]}, 32'd1);
        check("send_a_din", {16'd0, o_din[k]}, 32'(a));
        @(posedge clk);
        @(negedge clk);
        check("send_b_irdy", {31'd0, o_irdy[k]}, 32'd0);
        check("send_b_din", {16'd0, o_din[k]}, 32'(b));
        lat = 2;
        ok  = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (o_out_valid[k]) begin ok = 1'b1; break; end
        end
        check("result_wait", {31'd0, ok}, 32'd1);
        check("out_gcd", {16'd0, o_gcd[k]}, 32'(exp_gcd));
        check("out_err", {31'd0, o_err[k]}, {31'd0, exp_err});
        check("out_cycles", {15'd0, o_cycles[k]}, 32'(exp_cyc));
        check("latency", 32'(lat), 32'(3 + exp_cyc));
        check("irdy_pulses", 32'(irdy_count(k) - irdy0), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {31'd0, o_out_valid[k]}, 32'd1);
            check("hold_gcd", {16'd0, o_gcd[k]}, 32'(exp_gcd));
            check("hold_in_ready", {31'd0, o_in_ready[k]}, 32'd0);
            check("hold_irdy", {31'd0, o_irdy[k]}, 32'd0);
        end
        tb_out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!stream) tb_out_ready[k] = 1'b0;
        check("release_valid", {31'd0, o_out_valid[k]}, 32'd0);
        check("release_in_ready", {31'd0, o_in_ready[k]}, {31'd0, !exp_err});
        if (exp_err) begin
            prev_ordy = g_ordy[k];
            ok = 1'b0;
            for (int i = 0; i < 70000; i++) begin
                @(negedge clk);
                check("drain_irdy", {31'd0, o_irdy[k]}, 32'd0);
                if (o_in_ready[k]) begin ok = 1'b1; break; end
                prev_ordy = g_ordy[k];
            end
            check("drain_wait", {31'd0, ok}, 32'd1);
            check("drain_after_ordy", {31'd0, prev_ordy}, 32'd1);
        end
    endtask

    initial begin
        int ra;
        int rb;
        n_checks     = 0;
        n_errors     = 0;
        n_irdy0      = 0;
        n_irdy1      = 0;
        reset        = 1'b1;
        tb_in_valid  = 2'b00;
        tb_out_ready = 2'b00;
        for (int k = 0; k < 2; k++) begin
            tb_in_a[k] = '0;
            tb_in_b[k] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        reset = 1'b0;
        @(negedge clk);

        // directed operand cases
        run_op(0, 48, 18, 0, 1'b0, TO0);
        run_op(0, 0, 0, 0, 1'b0, TO0);
        run_op(0, 25, 0, 0, 1'b0, TO0);
        run_op(0, 0, 25, 0, 1'b0, TO0);
        run_op(0, 21, 14, 10, 1'b0, TO0);

        // random operand pairs
        for (int r = 0; r < 6; r++) begin
            ra = int'($urandom_range(0, 200));
            rb = int'($urandom_range(0, 200));
            run_op(0, ra, rb, int'($urandom_range(0, 3)), 1'b0, TO0);
        end

        // back-to-back stream with in_valid and out_ready held high
        tb_out_ready[0] = 1'b1;
        run_op(0, 48, 18, 0, 1'b1, TO0);
        run_op(0, 35, 25, 0, 1'b1, TO0);
        run_op(0, 17, 5, 0, 1'b1, TO0);
        run_op(0, 27, 18, 0, 1'b1, TO0);
        tb_in_valid[0]  = 1'b0;
        tb_out_ready[0] = 1'b0;
        @(negedge clk);

        // timeout, drain, then a normal op on the short-timeout instance
        run_op(1, 300, 1, 2, 1'b0, TO1);
        run_op(1, 12, 8, 0, 1'b0, TO1);

        // reset in the middle of WAIT
        tb_in_a[0]     = 16'd100;
        tb_in_b[0]     = 16'd75;
        tb_in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state(0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(0, 100, 75, 0, 1'b0, TO0);

        // worst-case subtraction chain under the default timeout
        run_op(0, 65535, 1, 0, 1'b0, TO0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
